approx_mult_seq: RTL and testbench



---
 rtl/approx_mult_seq.sv | 96 +++++++++
 tb/tb_approx_mult_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/approx_mult_seq.sv
// approx_mult_seq: sequential nibble-decomposed multiplier with exact, OR-combine and truncating accumulation
module approx_mult_seq #(
  parameter int W = 8,
  parameter int TRUNC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] R
);
  localparam int NW = W / 4;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  localparam logic [CW:0] TR = TRUNC[CW:0];
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0] mode_q, mode_d;
  logic [2*W-1:0] acc_q, acc_d, r_q, r_d, pp, acc_nx;
  logic [CW-1:0] i_q, i_d, j_q, j_d;
  logic [CW:0] sum;
  logic [7:0] prod;
  // one shifted partial product and the mode-dependent accumulator update
  always_comb begin
    sum = {1'b0, i_q} + {1'b0, j_q};
    prod = {4'b0, a_q[4*i_q +: 4]} * {4'b0, b_q[4*j_q +: 4]};
    pp = {{(2*W-8){1'b0}}, prod} << {sum, 2'b00};
    acc_nx = (mode_q == 2'd1) ? (acc_q | pp) :
             ((mode_q == 2'd2) && (sum < TR)) ? acc_q : (acc_q + pp);
  end
  // control: accept, step j inner / i outer, publish, wait for consumer
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    mode_d = mode_q;
    acc_d = acc_q;
    r_d = r_q;
    i_d = i_q;
    j_d = j_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = A;
        b_d = B;
        mode_d = mode;
        acc_d = '0;
        i_d = '0;
        j_d = '0;
        state_d = CALC;
      end
      CALC: begin
        acc_d = acc_nx;
        j_d = (j_q == LAST) ? '0 : j_q + CW'(1);
        i_d = (j_q == LAST) ? i_q + CW'(1) : i_q;
        if ((j_q == LAST) && (i_q == LAST)) begin
          r_d = acc_nx;
          i_d = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      mode_q <= '0;
      acc_q <= '0;
      r_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      mode_q <= mode_d;
      acc_q <= acc_d;
      r_q <= r_d;
      i_q <= i_d;
      j_q <= j_d;
    end
  end
  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign R = r_q;
endmodule

// File: tb/tb_approx_mult_seq.sv
// tb_approx_mult_seq: randomized and directed checks of approx_mult_seq at W=8 and W=16
module tb_approx_mult_seq;
  logic clk = 0, rst = 1, iv = 0, orr = 0, sel = 0;
  logic [15:0] a = 0, b = 0;
  logic [1:0] m = 0;
  logic ir8, ov8, ir16, ov16, ir, ov;
  logic [15:0] r8;
  logic [31:0] r16, r;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  approx_mult_seq #(.W(8), .TRUNC(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(ir8), .A(a[7:0]), .B(b[7:0]),
    .mode(m), .out_valid(ov8), .out_ready(orr & ~sel), .R(r8));
  approx_mult_seq #(.W(16), .TRUNC(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(ir16), .A(a), .B(b),
    .mode(m), .out_valid(ov16), .out_ready(orr & sel), .R(r16));
  assign ir = sel ? ir16 : ir8;
  assign ov = sel ? ov16 : ov8;
  assign r = sel ? r16 : {16'b0, r8};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input int nw, input int tr, input logic [15:0] x,
                                        input logic [15:0] y, input logic [1:0] md);
    logic [31:0] acc = 0, p;
    for (int i = 0; i < nw; i++)
      for (int j = 0; j < nw; j++) begin
        p = 32'(((int'(x) >> (4 * i)) & 15) * ((int'(y) >> (4 * j)) & 15)) << (4 * (i + j));
        if (md == 2'd1) acc = acc | p;
        else if (!(md == 2'd2 && i + j < tr)) acc = acc + p;
      end
    return acc;
  endfunction
  task automatic op(input logic w, input logic [15:0] x, input logic [15:0] y, input logic [1:0] md,
                    input int stall, output logic [31:0] res, output int lat);
    sel = w;
    a = x;
    b = y;
    m = md;
    iv = 1;
    @(posedge clk); #1;
    iv = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    m = 2'($urandom);
    lat = 0;
    while (!ov && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = r;
    iv = 1;
    repeat (stall) begin
      @(posedge clk); #1;
      check("stall", {ov, ir, r}, {1'b1, 1'b0, res});
    end
    iv = 0;
    orr = 1;
    @(posedge clk); #1;
    orr = 0;
    check("handshake", {ov, ir, r}, {1'b0, 1'b1, res});
  endtask
  initial begin
    logic [31:0] res;
    logic [15:0] x, y;
    logic [1:0] md;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    sel = 0;
    check("reset8", {ov, ir, r}, {1'b0, 1'b1, 32'h0});
    sel = 1;
    check("reset16", {ov, ir, r}, {1'b0, 1'b1, 32'h0});
    rst = 0;
    op(0, 16'hFF, 16'hFF, 0, 0, res, lat);
    check("exact_ff", res, 32'hFE01);
    check("lat8", lat, 4);
    op(0, 16'hFF, 16'hFF, 1, 0, res, lat);
    check("or_ff", res, 32'hEFF1);
    check("lat8_or", lat, 4);
    op(0, 16'hFF, 16'hFF, 2, 0, res, lat);
    check("trunc_ff", res, 32'hFD20);
    check("lat8_trunc", lat, 4);
    op(0, 16'hFF, 16'hFF, 3, 0, res, lat);
    check("mode3_ff", res, 32'hFE01);
    op(0, 16'h12, 16'h34, 0, 10, res, lat);
    check("stall_res", res, 32'h03A8);
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_after", {ov, ir, r}, {1'b0, 1'b1, 32'h03A8});
    end
    for (int k = 0; k < 4; k++) begin
      op(0, 16'h0, 16'($urandom_range(0, 255)), 2'(k), 0, res, lat);
      check("zero_a", res, 32'h0);
    end
    sel = 0;
    a = 16'hAB;
    b = 16'hCD;
    m = 0;
    iv = 1;
    @(posedge clk); #1;
    iv = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("mid_reset", {ov, ir, r}, {1'b0, 1'b1, 32'h0});
    repeat (6) begin
      @(posedge clk); #1;
      check("no_output", ov, 1'b0);
    end
    op(0, 16'h3, 16'h5, 0, 0, res, lat);
    check("after_reset", res, 32'h000F);
    op(1, 16'hFFFF, 16'hFFFF, 0, 2, res, lat);
    check("exact_ffff", res, 32'hFFFE0001);
    check("lat16", lat, 16);
    for (int k = 0; k < 60; k++) begin
      logic w;
      w = k[0];
      x = w ? 16'($urandom) : 16'($urandom_range(0, 255));
      y = w ? 16'($urandom) : 16'($urandom_range(0, 255));
      md = 2'($urandom);
      op(w, x, y, md, $urandom_range(0, 3), res, lat);
      check(w ? "rand16" : "rand8", res, model(w ? 4 : 2, 1, x, y, md));
      check("rand_lat", lat, w ? 16 : 4);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
